// File: rtl/contador_updown_if.sv
// -----------------------------------------------------------------------------
// contador_updown_if
// Control and status bundle for the contador_updown up/down counter.
//
// Signals (WIDTH = counter width):
//   ud    1      direction: 1 = count up, 0 = count down
//   en    1      count enable for the next rising clock edge
//   load  1      synchronous parallel load strobe (wins over en)
//   din   WIDTH  parallel load value
//   cont  WIDTH  current registered count
//   tc    1      terminal count for the current direction
//   zero  1      high when cont == 0
//
// Modports:
//   master : drives ud/en/load/din, observes cont/tc/zero
//   slave  : the counter itself
// -----------------------------------------------------------------------------
interface contador_updown_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ud;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] cont;
    logic             tc;
    logic             zero;

    modport master (
        output ud, en, load, din,
        input  cont, tc, zero
    );

    modport slave (
        input  ud, en, load, din,
        output cont, tc, zero
    );
endinterface : contador_updown_if

// File: rtl/contador_updown.sv
// -----------------------------------------------------------------------------
// contador_updown
// General-purpose WIDTH-bit up/down event/position counter with parallel load.
// One step per enabled rising clock edge; load has priority over counting.
// At the limits the counter either wraps (SATURATE = 0) or holds (SATURATE = 1).
//
// Parameters:
//   WIDTH     counter width in bits, legal range 2..32
//   SATURATE  0 = modulo-2^WIDTH wrap, 1 = hold at 0 / MAX
//
// Ports:
//   clk   input   rising-edge clock
//   rst   input   asynchronous active-low reset, clears the count immediately
//   bus   slave   ud/en/load/din controls, cont/tc/zero status
//                 (cont registered; tc and zero are decoded from cont and ud)
// -----------------------------------------------------------------------------
module contador_updown #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    contador_updown_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               SAT      = (SATURATE != 0);

    logic [WIDTH-1:0] cont_q;
    logic [WIDTH-1:0] cont_d;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (cont_q == MAX_VAL);
    assign at_zero = (cont_q == ZERO_VAL);

    // Next-state selection: load, then count, then hold.
    always_comb begin
        // NOTE: default assignment first so every path assigns cont_d and no latch is inferred.
        cont_d = cont_q;
        if (bus.load) begin
            cont_d = bus.din;
        end else if (bus.en) begin
            if (bus.ud) begin
                // Plain addition already wraps MAX -> 0; saturation only has to block it.
                if (!(SAT && at_max)) begin
                    cont_d = cont_q + ONE_VAL;
                end
            end else begin
                if (!(SAT && at_zero)) begin
                    cont_d = cont_q - ONE_VAL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments for registers so every flop samples pre-edge values.
        if (!rst) begin
            cont_q <= ZERO_VAL;
        end else begin
            cont_q <= cont_d;
        end
    end

    // Status decode: tc tracks ud without waiting for a clock edge.
    assign bus.cont = cont_q;
    assign bus.zero = at_zero;
    assign bus.tc   = bus.ud ? at_max : at_zero;

endmodule : contador_updown

// File: tb/tb_contador_updown.sv
// -----------------------------------------------------------------------------
// tb_contador_updown
// Drives one wrapping and one saturating counter with identical directed
// stimulus. The driver pushes hand-computed expected counts into a queue; an
// independent monitor pops and compares on every falling clock edge, or at
// once when an asynchronous check is requested.
// -----------------------------------------------------------------------------
module tb_contador_updown;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst = 1'b0;
    logic       ud_d = 1'b0;
    logic       en_d = 1'b0;
    logic       load_d = 1'b0;
    logic [7:0] din_d = 8'h00;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        bit         sat;
        logic [7:0] cont;
        logic       ud;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    event async_ev;

    // Clock can be paused (held low) to prove reset needs no edge.
    always #5 if (clk_run) clk = ~clk;

    contador_updown_if #(.WIDTH(8)) if_w ();
    contador_updown_if #(.WIDTH(8)) if_s ();

    assign if_w.ud = ud_d;   assign if_s.ud = ud_d;
    assign if_w.en = en_d;   assign if_s.en = en_d;
    assign if_w.load = load_d; assign if_s.load = load_d;
    assign if_w.din = din_d; assign if_s.din = din_d;

    contador_updown #(.WIDTH(8), .SATURATE(0)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (if_w)
    );

    contador_updown #(.WIDTH(8), .SATURATE(1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (if_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [7:0] exp_w, input logic [7:0] exp_s);
        exp_t e;
        e.name = {name, "/wrap"}; e.sat = 1'b0; e.cont = exp_w; e.ud = ud_d;
        q.push_back(e);
        e.name = {name, "/sat"};  e.sat = 1'b1; e.cont = exp_s; e.ud = ud_d;
        q.push_back(e);
    endtask

    // Apply inputs, let one rising edge pass, queue expectations for that edge.
    task automatic step(input logic ld, input logic [7:0] d, input logic e, input logic u,
                        input logic [7:0] exp_w, input logic [7:0] exp_s, input string name);
        load_d = ld; din_d = d; en_d = e; ud_d = u;
        @(posedge clk);
        #1;
        push(name, exp_w, exp_s);
        @(negedge clk);
        #1;
    endtask

    // Check without waiting for a clock edge.
    task automatic async_chk(input string name, input logic [7:0] exp_w, input logic [7:0] exp_s);
        push(name, exp_w, exp_s);
        -> async_ev;
        #1;
    endtask

    // Monitor: compares every queued expectation against the selected DUT.
    initial begin
        forever begin
            @(negedge clk or async_ev);
            while (q.size() > 0) begin
                mon_e = q.pop_front();
                check({mon_e.name, ".cont"},
                      mon_e.sat ? if_s.cont : if_w.cont, mon_e.cont);
                check({mon_e.name, ".zero"},
                      mon_e.sat ? if_s.zero : if_w.zero, mon_e.cont == 8'h00);
                check({mon_e.name, ".tc"},
                      mon_e.sat ? if_s.tc : if_w.tc,
                      mon_e.ud ? (mon_e.cont == 8'hFF) : (mon_e.cont == 8'h00));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-up reset over a few edges, then release.
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;

        // Asynchronous reset with the clock stopped.
        step(1'b1, 8'h37, 1'b0, 1'b1, 8'h37, 8'h37, "load37");
        clk_run = 1'b0;
        rst = 1'b0;
        #1;
        async_chk("rst_async_up", 8'h00, 8'h00);
        ud_d = 1'b0;
        #1;
        async_chk("rst_async_dn", 8'h00, 8'h00);
        clk_run = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, "rst_hold");
        rst = 1'b1;

        // Up four, then down two.
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 8'h01, "up1");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 8'h02, "up2");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 8'h03, "up3");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 8'h04, "up4");
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 8'h03, "dn1");
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 8'h02, "dn2");

        // Upper limit: wrap vs hold.
        step(1'b1, 8'hFE, 1'b1, 1'b1, 8'hFE, 8'hFE, "loadFE");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF, "top1");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'hFF, "top2");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 8'hFF, "top3");

        // Lower limit: wrap vs hold.
        step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, "load00");
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, "under");
        step(1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 8'h01, "load01");
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, "bot1");
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, "bot2");
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'hFE, 8'h00, "bot3");

        // Load beats enable; then hold with en = 0.
        step(1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 8'hA5, "prio");
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 8'hA5, "hold1");
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 8'hA5, "hold2");
        step(1'b0, 8'h3C, 1'b0, 1'b1, 8'hA5, 8'hA5, "hold3");

        // tc follows ud between edges.
        step(1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 8'hFF, "loadFF");
        ud_d = 1'b0;
        #1;
        async_chk("tc_ud_flip", 8'hFF, 8'hFF);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, "tc_hold");

        // Reset mid-count overrides load/en; resume from 0.
        step(1'b1, 8'h0F, 1'b0, 1'b1, 8'h0F, 8'h0F, "load0F");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'h10, "to10");
        rst = 1'b0;
        #1;
        async_chk("rst_mid", 8'h00, 8'h00);
        step(1'b1, 8'h77, 1'b1, 1'b1, 8'h00, 8'h00, "rst_over_load");
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 8'h01, "resume1");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 8'h02, "resume2");

        repeat (2) @(negedge clk);
        #1;
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            total++;
            bad++;
            $display("FAIL unchecked %s: got pending expected consumed", mon_e.name);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_contador_updown
